vga_pattern_gen: RTL and testbench

- Sits directly downstream of `vga_sync` and consumes its counters and sync pulses.
- Generates a selectable test pattern as RGB565 pixel data.
- Registers the pixel data and realigns HSYNC/VSYNC so that colour and sync leave the block on the same cycle.
- Pattern changes and animation update only at frame boundaries, so no frame ever shows a torn pattern.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_box_ctrl.sv | 73 +++++++
 rtl/vga_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, pattern/box enums and the RGB565 pixel type.
package vga_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned H_TOTAL    = 800;
  localparam int unsigned V_TOTAL    = 525;
  localparam int unsigned BAR_WIDTH  = 80;
  localparam int unsigned RAMP_WIDTH = 20;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_BOX     = 2'd3
  } pattern_e;

  typedef enum logic {
    MOVE_RIGHT = 1'b0,
    MOVE_LEFT  = 1'b1
  } box_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t RGB_BLACK = '{r: 5'd0,  g: 6'd0,  b: 5'd0};
  localparam rgb565_t RGB_WHITE = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t RGB_BLUE  = '{r: 5'd0,  g: 6'd0,  b: 5'd31};

endpackage

// File: rtl/vga_box_ctrl.sv
// Horizontal position controller for the bouncing box; steps once per frame.
//
// state      | meaning
// -----------+--------------------------------------------------------
// MOVE_RIGHT | box_x grows by BoxStep each frame, clamps at right edge
// MOVE_LEFT  | box_x shrinks by BoxStep each frame, clamps at 0
module vga_box_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned BoxSize = 64,
  parameter int unsigned BoxStep = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  output logic [9:0] box_x
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BoxSize);
  localparam logic [9:0] STEP  = 10'(BoxStep);

  box_state_e  state_q, state_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [10:0] sum;

  // State and position register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MOVE_RIGHT;
      box_x_q <= '0;
    end else begin
      state_q <= state_d;
      box_x_q <= box_x_d;
    end
  end

  // Next state: move only on the frame-start strobe; clamp before any wrap
  always_comb begin
    state_d = state_q;
    box_x_d = box_x_q;
    sum     = {1'b0, box_x_q} + {1'b0, STEP};
    if (frame_start) begin
      case (state_q)
        MOVE_RIGHT: begin
          if (sum >= {1'b0, X_MAX}) begin
            box_x_d = X_MAX;
            state_d = MOVE_LEFT;
          end else begin
            box_x_d = sum[9:0];
          end
        end
        MOVE_LEFT: begin
          if (box_x_q <= STEP) begin
            box_x_d = '0;
            state_d = MOVE_RIGHT;
          end else begin
            box_x_d = box_x_q - STEP;
          end
        end
        default: begin
          box_x_d = '0;
          state_d = MOVE_RIGHT;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    box_x = box_x_q;
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator behind vga_sync: two-stage pipeline, RGB565 out,
// syncs delayed to match the pixel data exactly.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned BoxSize = 64,
  parameter int unsigned BoxStep = 4,
  parameter int unsigned BoxY    = 208
) (
  input  logic       Clock25,
  input  logic       ResetN,
  input  logic       HorizontalSync,
  input  logic       VerticalSync,
  input  logic [9:0] HorizontalCounter,
  input  logic [9:0] VerticalCounter,
  input  logic [1:0] PatternSel,
  output logic       HSyncOut,
  output logic       VSyncOut,
  output logic [4:0] Red,
  output logic [5:0] Green,
  output logic [4:0] Blue,
  output logic [7:0] FrameCount
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE);
  localparam logic [9:0] BOX_W     = 10'(BoxSize);
  localparam logic [9:0] BOX_Y_LO  = 10'(BoxY);
  localparam logic [9:0] BOX_Y_HI  = 10'(BoxY + BoxSize);
  localparam logic [6:0] BAR_LAST  = 7'(BAR_WIDTH - 1);
  localparam logic [4:0] RAMP_LAST = 5'(RAMP_WIDTH - 1);

  logic       frame_start, h_in_active, v_in_active, h_advance, in_box;
  logic [9:0] box_x;

  pattern_e   mode_q, mode_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       run_q, run_d;

  logic       act1_q, act1_d;
  logic [9:0] x1_q, x1_d, y1_q, y1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  logic [6:0] bar_sub_q, bar_sub_d;
  logic [4:0] ramp_lvl_q, ramp_lvl_d;
  logic [4:0] ramp_sub_q, ramp_sub_d;

  rgb565_t    rgb2_q, rgb2_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d;

  vga_box_ctrl #(
    .BoxSize (BoxSize),
    .BoxStep (BoxStep)
  ) u_box_ctrl (
    .clk         (Clock25),
    .rst_n       (ResetN),
    .frame_start (frame_start),
    .box_x       (box_x)
  );

  // Counter decode; anything outside the visible window counts as blanking
  always_comb begin
    h_in_active = (HorizontalCounter >= 10'd1) && (HorizontalCounter <= H_LAST);
    v_in_active = (VerticalCounter >= 10'd1) && (VerticalCounter <= V_LAST);
    h_advance   = (HorizontalCounter >= 10'd2) && (HorizontalCounter <= H_LAST);
    frame_start = (HorizontalCounter == 10'd1) && (VerticalCounter == 10'd1);
  end

  // Frame-boundary state: pattern latch, frame counter, output enable after reset
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    run_d       = run_q;
    if (frame_start) begin
      mode_d      = pattern_e'(PatternSel);
      frame_cnt_d = frame_cnt_q + 8'd1;
      run_d       = 1'b1;
    end
  end

  // Stage 1: coordinates, active flag, syncs and the bar/ramp sub-counters
  always_comb begin
    act1_d     = h_in_active && v_in_active && (run_q || frame_start);
    x1_d       = HorizontalCounter - 10'd1;
    y1_d       = VerticalCounter - 10'd1;
    hs1_d      = HorizontalSync;
    vs1_d      = VerticalSync;
    bar_idx_d  = bar_idx_q;
    bar_sub_d  = bar_sub_q;
    ramp_lvl_d = ramp_lvl_q;
    ramp_sub_d = ramp_sub_q;
    if (HorizontalCounter == 10'd1) begin
      bar_idx_d  = '0;
      bar_sub_d  = '0;
      ramp_lvl_d = '0;
      ramp_sub_d = '0;
    end else if (h_advance) begin
      if (bar_sub_q == BAR_LAST) begin
        bar_sub_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_sub_d = bar_sub_q + 7'd1;
      end
      if (ramp_sub_q == RAMP_LAST) begin
        ramp_sub_d = '0;
        ramp_lvl_d = ramp_lvl_q + 5'd1;
      end else begin
        ramp_sub_d = ramp_sub_q + 5'd1;
      end
    end
  end

  // Stage 2: colour mux; bar index bit 1 removes red, bit 0 removes blue, bit 2 removes green
  always_comb begin
    in_box = (x1_q >= box_x) && (x1_q < box_x + BOX_W) &&
             (y1_q >= BOX_Y_LO) && (y1_q < BOX_Y_HI);
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;
    rgb2_d = RGB_BLACK;
    if (act1_q) begin
      case (mode_q)
        PAT_BARS: begin
          rgb2_d.r = bar_idx_q[1] ? 5'd0 : 5'd31;
          rgb2_d.g = bar_idx_q[2] ? 6'd0 : 6'd63;
          rgb2_d.b = bar_idx_q[0] ? 5'd0 : 5'd31;
        end
        PAT_CHECKER: rgb2_d = (x1_q[5] ^ y1_q[5]) ? RGB_BLACK : RGB_WHITE;
        PAT_RAMP: begin
          rgb2_d.r = ramp_lvl_q;
          rgb2_d.g = {ramp_lvl_q, 1'b0};
          rgb2_d.b = ramp_lvl_q;
        end
        PAT_BOX:  rgb2_d = in_box ? RGB_WHITE : RGB_BLUE;
        default:  rgb2_d = RGB_BLACK;
      endcase
    end
  end

  // All registers; reset blanks the pipeline and parks syncs high
  always_ff @(posedge Clock25) begin
    if (!ResetN) begin
      mode_q      <= PAT_BARS;
      frame_cnt_q <= '0;
      run_q       <= 1'b0;
      act1_q      <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      bar_idx_q   <= '0;
      bar_sub_q   <= '0;
      ramp_lvl_q  <= '0;
      ramp_sub_q  <= '0;
      rgb2_q      <= RGB_BLACK;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      run_q       <= run_d;
      act1_q      <= act1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      bar_idx_q   <= bar_idx_d;
      bar_sub_q   <= bar_sub_d;
      ramp_lvl_q  <= ramp_lvl_d;
      ramp_sub_q  <= ramp_sub_d;
      rgb2_q      <= rgb2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
    end
  end

  assign Red        = rgb2_q.r;
  assign Green      = rgb2_q.g;
  assign Blue       = rgb2_q.b;
  assign HSyncOut   = hs2_q;
  assign VSyncOut   = vs2_q;
  assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen; the bench plays the role of vga_sync.
module tb_vga_pattern_gen;

  logic       Clock25 = 1'b0;
  logic       ResetN = 1'b0;
  logic       HorizontalSync = 1'b1;
  logic       VerticalSync = 1'b1;
  logic [9:0] HorizontalCounter = 10'd700;
  logic [9:0] VerticalCounter = 10'd491;
  logic [1:0] PatternSel = 2'd0;
  logic       HSyncOut, VSyncOut;
  logic [4:0] Red, Blue;
  logic [5:0] Green;
  logic [7:0] FrameCount;

  int n_checks = 0;
  int n_fail = 0;
  int n_frames = 0;
  int bx;

  logic [15:0] cap_rgb [0:1023];
  logic        cap_hs  [0:1023];
  logic        cap_vs  [0:1023];
  logic [9:0]  hist1_h = 10'd900;
  logic [9:0]  hist2_h = 10'd900;

  always #5 Clock25 = ~Clock25;

  vga_pattern_gen #(
    .BoxSize (64),
    .BoxStep (4),
    .BoxY    (208)
  ) dut (
    .Clock25           (Clock25),
    .ResetN            (ResetN),
    .HorizontalSync    (HorizontalSync),
    .VerticalSync      (VerticalSync),
    .HorizontalCounter (HorizontalCounter),
    .VerticalCounter   (VerticalCounter),
    .PatternSel        (PatternSel),
    .HSyncOut          (HSyncOut),
    .VSyncOut          (VSyncOut),
    .Red               (Red),
    .Green             (Green),
    .Blue              (Blue),
    .FrameCount        (FrameCount)
  );

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  // Box position after k frame starts since reset: 0,4,..,576 then back down to 0
  function automatic int exp_box(input int k);
    int p;
    p = k % 288;
    if (p <= 144) return 4 * p;
    return 576 - 4 * (p - 144);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: capture the output belonging to the input driven two calls ago, then drive
  task automatic drive(input int h, input int v);
    @(negedge Clock25);
    cap_rgb[hist2_h] = {Red, Green, Blue};
    cap_hs[hist2_h]  = HSyncOut;
    cap_vs[hist2_h]  = VSyncOut;
    hist2_h = hist1_h;
    hist1_h = 10'(h);
    HorizontalCounter = 10'(h);
    VerticalCounter   = 10'(v);
    HorizontalSync    = !(h >= 657 && h <= 752);
    VerticalSync      = !(v >= 491 && v <= 492);
  endtask

  task automatic flush();
    drive(900, 900);
    drive(900, 900);
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic [15:0] exp);
    drive(h, v);
    flush();
    chk(tag, 32'(cap_rgb[10'(h)]), 32'(exp));
  endtask

  task automatic sweep(input int v);
    if (v == 1) n_frames++;
    for (int h = 1; h <= 800; h++) drive(h, v);
    flush();
  endtask

  task automatic frame_start();
    drive(1, 1);
    n_frames++;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not end, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    // Reset held 3 cycles with both syncs driven low
    for (int i = 0; i < 3; i++) drive(700, 491);
    chk("rst_rgb", 32'({Red, Green, Blue}), 32'h0);
    chk("rst_hs", 32'(HSyncOut), 32'h1);
    chk("rst_vs", 32'(VSyncOut), 32'h1);
    chk("rst_fc", 32'(FrameCount), 32'h0);
    ResetN = 1'b1;

    // Frame 1, bars
    sweep(1);
    chk("first_pixel", 32'(cap_rgb[1]), 32'(rgb(31, 63, 31)));
    chk("fc_1", 32'(FrameCount), 32'd1);
    chk("hs_before", 32'(cap_hs[656]), 32'h1);
    chk("hs_first_low", 32'(cap_hs[657]), 32'h0);
    chk("hs_last_low", 32'(cap_hs[752]), 32'h0);
    chk("hs_after", 32'(cap_hs[753]), 32'h1);

    sweep(101);
    chk("bar_x0", 32'(cap_rgb[1]), 32'(rgb(31, 63, 31)));
    chk("bar_x79", 32'(cap_rgb[80]), 32'(rgb(31, 63, 31)));
    chk("bar_x80", 32'(cap_rgb[81]), 32'(rgb(31, 63, 0)));
    chk("bar_x160", 32'(cap_rgb[161]), 32'(rgb(0, 63, 31)));
    chk("bar_x400", 32'(cap_rgb[401]), 32'(rgb(31, 0, 0)));
    chk("bar_x639", 32'(cap_rgb[640]), 32'(rgb(0, 0, 0)));
    chk("bar_x640", 32'(cap_rgb[641]), 32'(rgb(0, 0, 0)));
    chk("bar_x700", 32'(cap_rgb[701]), 32'(rgb(0, 0, 0)));

    probe("blank_h0", 0, 101, 16'h0);
    probe("blank_h1000", 1000, 101, 16'h0);
    probe("blank_v600", 300, 600, 16'h0);
    probe("blank_v0", 300, 0, 16'h0);
    drive(100, 490);
    drive(101, 491);
    flush();
    chk("vs_before", 32'(cap_vs[100]), 32'h1);
    chk("vs_low", 32'(cap_vs[101]), 32'h0);

    // Mid-frame request for checkerboard: rest of this frame stays bars
    PatternSel = 2'd1;
    sweep(200);
    chk("switch_hold_x80", 32'(cap_rgb[81]), 32'(rgb(31, 63, 0)));
    chk("switch_hold_x0", 32'(cap_rgb[1]), 32'(rgb(31, 63, 31)));
    sweep(1);
    chk("chk_0_0", 32'(cap_rgb[1]), 32'(rgb(31, 63, 31)));
    chk("chk_32_0", 32'(cap_rgb[33]), 32'(rgb(0, 0, 0)));
    sweep(33);
    chk("chk_32_32", 32'(cap_rgb[33]), 32'(rgb(31, 63, 31)));
    chk("chk_0_32", 32'(cap_rgb[1]), 32'(rgb(0, 0, 0)));
    chk("fc_2", 32'(FrameCount), 32'd2);

    // Grey ramp
    PatternSel = 2'd2;
    sweep(1);
    chk("ramp_x19", 32'(cap_rgb[20]), 32'(rgb(0, 0, 0)));
    chk("ramp_x20", 32'(cap_rgb[21]), 32'(rgb(1, 2, 1)));
    chk("ramp_x639", 32'(cap_rgb[640]), 32'(rgb(31, 62, 31)));

    // Moving box over 150 frames, across the right-edge turn
    PatternSel = 2'd3;
    for (int f = 0; f < 150; f++) begin
      frame_start();
      bx = exp_box(n_frames);
      probe($sformatf("box_l_in f%0d", n_frames), bx + 1, 209, rgb(31, 63, 31));
      if (bx > 0) probe($sformatf("box_l_out f%0d", n_frames), bx, 209, rgb(0, 0, 31));
      probe($sformatf("box_r_in f%0d", n_frames), bx + 64, 209, rgb(31, 63, 31));
      probe($sformatf("box_r_out f%0d", n_frames), bx + 65, 209,
            (bx + 64 < 640) ? rgb(0, 0, 31) : rgb(0, 0, 0));
      probe($sformatf("box_top_out f%0d", n_frames), bx + 1, 208, rgb(0, 0, 31));
      probe($sformatf("box_bot_in f%0d", n_frames), bx + 1, 272, rgb(31, 63, 31));
      probe($sformatf("box_bot_out f%0d", n_frames), bx + 1, 273, rgb(0, 0, 31));
    end
    chk("fc_153", 32'(FrameCount), 32'd153);

    // Frame counter wrap
    while (n_frames < 255) frame_start();
    flush();
    chk("fc_255", 32'(FrameCount), 32'd255);
    frame_start();
    flush();
    chk("fc_wrap", 32'(FrameCount), 32'd0);

    // Reset in the middle of line 300
    drive(200, 301);
    drive(201, 301);
    ResetN = 1'b0;
    drive(202, 301);
    chk("midrst_blank", 32'(cap_rgb[200]), 32'h0);
    chk("midrst_fc", 32'(FrameCount), 32'h0);
    ResetN = 1'b1;
    probe("partial_blank", 250, 301, 16'h0);
    probe("partial_blank2", 400, 400, 16'h0);
    n_frames = 0;
    frame_start();
    probe("rst_box_in", 5, 209, rgb(31, 63, 31));
    probe("rst_box_out", 4, 209, rgb(0, 0, 31));
    chk("rst_fc_1", 32'(FrameCount), 32'd1);
    frame_start();
    probe("rst_dir_in", 9, 209, rgb(31, 63, 31));
    probe("rst_dir_out", 8, 209, rgb(0, 0, 31));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
